// File: rtl/fft_stream_ctrl_if.sv
// Stream-side and core-side signal bundle for fft_stream_ctrl.
// master = the controller, slave = the surrounding system (source, sink and fft core).
interface fft_stream_ctrl_if #(
  parameter int D_WIDTH     = 64,
  parameter int LOG_2_WIDTH = 6
);
  // Handshakes: a transfer happens at a falling clk edge where valid & ready are
  // both high; valid never depends on ready, and data is stable while valid is high.
  logic                     in_valid;
  logic                     in_ready;
  logic [15:0]              in_re;
  logic [15:0]              in_im;
  logic [D_WIDTH-1:0][15:0] fft_re_in;
  logic [D_WIDTH-1:0][15:0] fft_im_in;
  logic                     fft_start;
  logic                     fft_done;
  logic [D_WIDTH-1:0][15:0] fft_re_out;
  logic [D_WIDTH-1:0][15:0] fft_im_out;
  logic                     out_valid;
  logic                     out_ready;
  logic [15:0]              out_re;
  logic [15:0]              out_im;
  logic [LOG_2_WIDTH-1:0]   out_index;
  logic                     out_last;
  logic                     busy;
  logic [1:0]               dbg_state;

  modport master (
    input  in_valid, in_re, in_im, fft_done, fft_re_out, fft_im_out, out_ready,
    output in_ready, fft_re_in, fft_im_in, fft_start, out_valid, out_re, out_im,
           out_index, out_last, busy, dbg_state
  );

  modport slave (
    output in_valid, in_re, in_im, fft_done, fft_re_out, fft_im_out, out_ready,
    input  in_ready, fft_re_in, fft_im_in, fft_start, out_valid, out_re, out_im,
           out_index, out_last, busy, dbg_state
  );
endinterface

// File: rtl/fft_stream_ctrl.sv
// Serial-to-parallel frame loader, start/done sequencer and serial result drain
// for the 64-point fft core. All state moves on the falling clock edge.
module fft_stream_ctrl #(
  parameter int D_WIDTH     = 64,
  parameter int LOG_2_WIDTH = 6
) (
  input  logic              clk,
  input  logic              rst,
  fft_stream_ctrl_if.master bus
);
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam logic [LOG_2_WIDTH-1:0] LAST = LOG_2_WIDTH'(D_WIDTH - 1);

  state_t                   state;
  state_t                   state_nx;
  logic [LOG_2_WIDTH-1:0]   wr_idx;
  logic [LOG_2_WIDTH-1:0]   rd_idx;
  logic                     full;
  logic [D_WIDTH-1:0][15:0] buf_re;
  logic [D_WIDTH-1:0][15:0] buf_im;
  logic                     accept;
  logic                     out_hs;

  assign accept = bus.in_valid & bus.in_ready;
  assign out_hs = bus.out_valid & bus.out_ready;

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (full) state_nx = START;
      START:   state_nx = RUN;
      RUN:     if (bus.fft_done) state_nx = DRAIN;
      DRAIN:   if (out_hs && (rd_idx == LAST)) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // The buffer is written only on accepts, and accepts are blocked in START,
  // so the core always samples a stable frame.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      wr_idx <= '0;
      full   <= 1'b0;
      buf_re <= '0;
      buf_im <= '0;
    end else begin
      if (accept) begin
        buf_re[wr_idx] <= bus.in_re;
        buf_im[wr_idx] <= bus.in_im;
        wr_idx         <= wr_idx + 1'b1;
        if (wr_idx == LAST) full <= 1'b1;
      end
      if (state == START) full <= 1'b0;
    end
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      rd_idx <= '0;
    end else if ((state == RUN) && bus.fft_done) begin
      rd_idx <= '0;
    end else if ((state == DRAIN) && out_hs) begin
      rd_idx <= rd_idx + 1'b1;
    end
  end

  assign bus.in_ready  = ~full & (state != START);
  assign bus.fft_start = (state == START);
  assign bus.busy      = (state != IDLE);
  assign bus.fft_re_in = buf_re;
  assign bus.fft_im_in = buf_im;
  assign bus.dbg_state = state;

  // The core holds its outputs until the next start, so results are muxed
  // straight from its ports rather than copied.
  always_comb begin
    bus.out_valid = 1'b0;
    bus.out_re    = '0;
    bus.out_im    = '0;
    bus.out_index = '0;
    bus.out_last  = 1'b0;
    if (state == DRAIN) begin
      bus.out_valid = 1'b1;
      bus.out_re    = bus.fft_re_out[rd_idx];
      bus.out_im    = bus.fft_im_out[rd_idx];
      bus.out_index = rd_idx;
      bus.out_last  = (rd_idx == LAST);
    end
  end
endmodule

// File: tb/tb_fft_stream_ctrl.sv
// Directed-plus-random bench for fft_stream_ctrl with a behavioural fft core stub.
// DUT updates on negedge; the bench drives and samples on posedge.
module tb_fft_stream_ctrl;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  fft_stream_ctrl_if #(.D_WIDTH(64), .LOG_2_WIDTH(6)) bus ();

  fft_stream_ctrl #(.D_WIDTH(64), .LOG_2_WIDTH(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          errors = 0;
  int          checks = 0;
  logic [15:0] exp_buf_re [64];
  logic [15:0] exp_buf_im [64];
  logic [38:0] exp_q[$];
  int          done_delay = 20;
  bit          fixed_out = 1'b1;
  int          cnt = 0;
  bit          start_prev = 1'b0;
  bit          buf_ok;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic void gen(input int kind, input int n,
                              output logic [15:0] re, output logic [15:0] im);
    case (kind)
      0: begin re = 16'h0100 + 16'(n); im = 16'(-n); end
      1: begin re = 16'h0500 + 16'(n); im = 16'($urandom); end
      default: begin re = 16'($urandom); im = 16'($urandom); end
    endcase
  endfunction

  // Core stub: checks the frame presented at start, then after done_delay
  // cycles presents results and pulses done; results are queued as expected output.
  always @(posedge clk) begin
    if (!rst) begin
      cnt          = 0;
      start_prev   = 1'b0;
      bus.fft_done = 1'b0;
      for (int i = 0; i < 64; i++) begin
        bus.fft_re_out[i] = 16'($urandom);
        bus.fft_im_out[i] = 16'($urandom);
      end
    end else begin
      if (bus.fft_done) begin
        bus.fft_done = 1'b0;
        chk("first_out_valid", 64'(bus.out_valid), 64'(1));
        chk("first_out_index", 64'(bus.out_index), 64'(0));
      end
      if (bus.fft_start) begin
        chk("start_single_cycle", 64'(start_prev), 64'(0));
        buf_ok = 1'b1;
        for (int i = 0; i < 64; i++)
          if (bus.fft_re_in[i] !== exp_buf_re[i] || bus.fft_im_in[i] !== exp_buf_im[i])
            buf_ok = 1'b0;
        chk("start_buffer", 64'(buf_ok), 64'(1));
        cnt = done_delay;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          for (int i = 0; i < 64; i++) begin
            logic [15:0] re, im;
            if (fixed_out) begin
              re = 16'h2000 + 16'(i);
              im = 16'h3000 - 16'(i);
            end else begin
              re = 16'($urandom);
              im = 16'($urandom);
            end
            bus.fft_re_out[i] = re;
            bus.fft_im_out[i] = im;
            exp_q.push_back({re, im, 6'(i), (i == 63)});
          end
          bus.fft_done = 1'b1;
        end
      end
      start_prev = bus.fft_start;
    end
  end

  // gap: 0 = random in_valid, 1 = continuous, k = high every k-th cycle.
  task automatic feed(input int kind, input int gap, input bit expect_start);
    int          n = 0;
    int          cyc = 0;
    bit          v;
    logic [15:0] re, im;
    gen(kind, 0, re, im);
    while (n < 64 && cyc < 3000) begin
      @(posedge clk);
      cyc++;
      if (gap == 0)      v = 1'($urandom_range(0, 1));
      else if (gap == 1) v = 1'b1;
      else               v = ((cyc % gap) == 0);
      bus.in_valid = v;
      bus.in_re    = re;
      bus.in_im    = im;
      if (v && bus.in_ready) begin
        exp_buf_re[n] = re;
        exp_buf_im[n] = im;
        n++;
        gen(kind, n, re, im);
      end
    end
    if (n < 64) chk("feed_timeout", 64'(n), 64'(64));
    @(posedge clk);
    bus.in_valid = 1'b0;
    chk("in_ready_after_fill", 64'(bus.in_ready), 64'(0));
    chk("no_start_at_fill", 64'(bus.fft_start), 64'(0));
    if (expect_start) begin
      @(posedge clk);
      chk("start_latency", 64'(bus.fft_start), 64'(1));
      chk("in_ready_in_start", 64'(bus.in_ready), 64'(0));
      if (kind == 0) begin
        chk("buf_re63", 64'(bus.fft_re_in[63]), 64'(16'h013F));
        chk("buf_im63", 64'(bus.fft_im_in[63]), 64'(16'hFFC1));
      end
      @(posedge clk);
      chk("start_dropped", 64'(bus.fft_start), 64'(0));
      chk("in_ready_back", 64'(bus.in_ready), 64'(1));
    end
  endtask

  // pattern: 0 = ready always, 1 = ready 1,0,0 repeating, 2 = random.
  task automatic drain(input int pattern, input int stop_after, input bit b2b);
    int hs = 0;
    int cyc = 0;
    bit rdy;
    while (hs < stop_after && cyc < 3000) begin
      @(posedge clk);
      cyc++;
      if (pattern == 0)      rdy = 1'b1;
      else if (pattern == 1) rdy = ((cyc % 3) == 1);
      else                   rdy = 1'($urandom_range(0, 1));
      bus.out_ready = rdy;
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          chk("out_unexpected", 64'(bus.out_valid), 64'(0));
        end else begin
          chk("out_sample", 64'({bus.out_re, bus.out_im, bus.out_index, bus.out_last}),
              64'(exp_q[0]));
          if (rdy) begin
            void'(exp_q.pop_front());
            hs++;
          end
        end
      end
    end
    if (hs < stop_after) chk("drain_timeout", 64'(hs), 64'(stop_after));
    if (stop_after == 64 && hs == 64) begin
      @(posedge clk);
      bus.out_ready = 1'b0;
      chk("busy_after_last", 64'(bus.busy), 64'(0));
      chk("valid_after_last", 64'(bus.out_valid), 64'(0));
      chk("no_start_at_last", 64'(bus.fft_start), 64'(0));
      if (b2b) begin
        @(posedge clk);
        chk("b2b_start", 64'(bus.fft_start), 64'(1));
        chk("b2b_ready_low", 64'(bus.in_ready), 64'(0));
        @(posedge clk);
        chk("b2b_ready_back", 64'(bus.in_ready), 64'(1));
        chk("b2b_start_drop", 64'(bus.fft_start), 64'(0));
      end
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'(1));
    chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'(0));
    chk({tag, "_out_last"}, 64'(bus.out_last), 64'(0));
    chk({tag, "_busy"}, 64'(bus.busy), 64'(0));
    chk({tag, "_fft_start"}, 64'(bus.fft_start), 64'(0));
    chk({tag, "_out_index"}, 64'(bus.out_index), 64'(0));
    chk({tag, "_out_re_im"}, 64'({bus.out_re, bus.out_im}), 64'(0));
    chk({tag, "_buffer_zero"}, 64'({bus.fft_re_in, bus.fft_im_in} == '0), 64'(1));
  endtask

  initial begin
    rst           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_re     = '0;
    bus.in_im     = '0;
    bus.out_ready = 1'b0;

    // Reset
    #12;
    check_idle_outputs("reset");
    @(posedge clk);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      chk("no_start_idle", 64'(bus.fft_start), 64'(0));
    end
    check_idle_outputs("post_reset");

    // Single frame, continuous input and output
    fork
      feed(0, 1, 1'b1);
      drain(0, 64, 1'b0);
    join

    // Output backpressure
    fork
      feed(0, 1, 1'b1);
      drain(1, 64, 1'b0);
    join

    // Input gaps
    fork
      feed(0, 3, 1'b1);
      drain(0, 64, 1'b0);
    join

    // Overlap: frame 2 loads entirely during frame 1's RUN
    done_delay = 100;
    fixed_out  = 1'b0;
    fork
      begin
        feed(0, 1, 1'b1);
        feed(1, 1, 1'b0);
      end
      drain(0, 64, 1'b1);
    join
    drain(0, 64, 1'b0);

    // Random frame with random gaps and random backpressure
    done_delay = $urandom_range(5, 30);
    fork
      feed(2, 0, 1'b1);
      drain(2, 64, 1'b0);
    join

    // Reset in the middle of DRAIN after bin 10
    fork
      feed(2, 1, 1'b1);
      drain(0, 11, 1'b0);
    join
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("midreset_out_valid", 64'(bus.out_valid), 64'(0));
    check_idle_outputs("midreset");
    bus.out_ready = 1'b0;
    exp_q.delete();
    @(posedge clk);
    @(posedge clk);
    rst = 1'b1;
    fixed_out  = 1'b1;
    done_delay = 20;
    fork
      feed(0, 1, 1'b1);
      drain(0, 64, 1'b0);
    join

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
